// File: rtl/conway_life_grid.sv
// Game of Life engine (B3/S23) over a ROWS x COLS grid with torus or dead-edge
// boundary, run/step control, a generation counter and still/period-2/extinct
// detection with optional auto-halt.
module conway_life_grid #(
    parameter int unsigned ROWS    = 16,
    parameter int unsigned COLS    = 16,
    parameter bit          WRAP    = 1'b1,
    parameter int unsigned GEN_W   = 16,
    parameter bit          HALT_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [ROWS*COLS-1:0]   data,
    input  logic                   run,
    input  logic                   step,
    output logic [ROWS*COLS-1:0]   q,
    output logic [GEN_W-1:0]       gen_count,
    output logic                   still,
    output logic                   period2,
    output logic                   extinct,
    output logic                   halted
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int          NR = int'(ROWS);
    localparam int          NC = int'(COLS);

    logic [N-1:0]     grid_q, prev_q, prev2_q;
    logic [N-1:0]     grid_d;
    logic [1:0]       hist_q;
    logic [GEN_W-1:0] gen_q;
    logic             advance;

    // Per-cell neighbour gather and B3/S23 rule; all cells update in parallel.
    for (genvar r = 0; r < NR; r++) begin : g_row
        for (genvar c = 0; c < NC; c++) begin : g_col
            logic [7:0] nbr;
            logic [3:0] cnt;

            for (genvar k = 0; k < 8; k++) begin : g_nbr
                // k walks the 8 neighbours in raster order, skipping the centre
                localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                localparam int DC = (k == 0 || k == 3 || k == 5) ? -1 :
                                    ((k == 1 || k == 6) ? 0 : 1);
                localparam int RR = r + DR;
                localparam int CC = c + DC;
                localparam bit INSIDE = (RR >= 0) && (RR < NR) && (CC >= 0) && (CC < NC);

                if (WRAP || INSIDE) begin : g_on
                    assign nbr[k] = grid_q[((RR + NR) % NR) * NC + ((CC + NC) % NC)];
                end else begin : g_off
                    assign nbr[k] = 1'b0;
                end
            end

            assign cnt = 4'($countones(nbr));
            assign grid_d[r*NC+c] = (cnt == 4'd3) || ((cnt == 4'd2) && grid_q[r*NC+c]);
        end
    end

    // Status decodes depend on registered state only.
    assign extinct = (grid_q == '0);
    assign still   = (hist_q != 2'd0) && (grid_q == prev_q);
    assign period2 = (hist_q == 2'd2) && (grid_q == prev2_q) && (grid_q != prev_q);
    assign halted  = HALT_EN && (still || period2 || extinct);

    // run and step merge into a single advance request; load always wins.
    assign advance = (run || step) && !halted && !load;

    // Grid, history and counter update with priority reset > load > advance > hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grid_q  <= '0;
            prev_q  <= '0;
            prev2_q <= '0;
            hist_q  <= 2'd0;
            gen_q   <= '0;
        end else if (load) begin
            grid_q  <= data;
            prev_q  <= '0;
            prev2_q <= '0;
            hist_q  <= 2'd0;
            gen_q   <= '0;
        end else if (advance) begin
            grid_q  <= grid_d;
            prev_q  <= grid_q;
            prev2_q <= prev_q;
            hist_q  <= (hist_q == 2'd2) ? 2'd2 : hist_q + 2'd1;
            gen_q   <= gen_q + GEN_W'(1);
        end
    end

    assign q         = grid_q;
    assign gen_count = gen_q;

endmodule
